audio_stream_player: RTL and testbench
======================================

AUDIO_STREAM_PLAYER -- requirements
Module: audio_stream_player

Interface
REQ-001 Parameter SAMPLE_W, default 8: bits per unsigned offset-binary sample; also the PWM resolution.
REQ-002 Parameter CHANNELS, default 2: number of independent audio channels.
REQ-003 Parameter DIV_W, default 32: width of the sample-rate divider.
REQ-004 Port clk  in  1: single system clock (clk_100mhz domain); all logic on rising edge.
REQ-005 Port reset  in  1: synchronous, active-low reset.
REQ-006 Port enable  in  1: playback enable.
REQ-007 Port rate_div  in  DIV_W: clk cycles per sample period; values below 4 are treated as 4.
REQ-008 Port volume  in  3: attenuation shift, 0 = full scale, 7 = maximum attenuation.
REQ-009 Port mute  in  1: force silence.
REQ-010 Port s_data  in  CHANNELS*SAMPLE_W: FIFO read data, channel 0 in the LSBs, valid the cycle after s_rd_en.
REQ-011 Port s_empty  in  1: FIFO empty flag.
REQ-012 Port s_rd_en  out  1: FIFO read strobe, one-cycle pulse.
REQ-013 Port pwm_out  out  CHANNELS: per-channel PWM audio output.
REQ-014 Port sample_tick  out  1: one-cycle pulse at each sample-period boundary.
REQ-015 Port underrun_count  out  16: saturating count of ticks taken while the FIFO was empty.
REQ-016 Port busy  out  1: high whenever the state is not IDLE.

Function
REQ-017 Tick counter SHALL count 0..eff_div-1 while enabled, where eff_div = max(rate_div, 4); sample_tick SHALL pulse in the cycle the count equals eff_div-1, and the count SHALL wrap to 0.
REQ-018 If rate_div drops mid-period so that count >= eff_div-1, the next cycle SHALL tick and wrap.
REQ-019 FSM states SHALL be IDLE, WAIT, FETCH and LATCH.
- IDLE to WAIT when enable is high.
- Any state to IDLE when enable is low.
REQ-020 WAIT, on tick with s_empty low: assert s_rd_en for exactly one cycle and go to FETCH.
REQ-021 WAIT, on tick with s_empty high: issue no read, set every level to midscale (2^(SAMPLE_W-1)), increment underrun_count saturating at 0xFFFF, and stay in WAIT.
REQ-022 FETCH to LATCH, one cycle. LATCH captures s_data into per-channel level registers and returns to WAIT.
- Sample-to-level latency: 2 cycles after tick.
REQ-023 Attenuation SHALL be applied per channel as level = mid + ((sample - mid) >>> volume).
- Arithmetic is signed with SAMPLE_W+1 bits; the result is clamped to 0..2^SAMPLE_W-1.
REQ-024 While mute is high, the compare value SHALL be midscale, effective on the following cycle. Level registers keep updating while muted.
REQ-025 Each channel SHALL share a free-running SAMPLE_W-bit PWM counter.
- pwm_out[c] = (pwm_cnt < compare[c]), registered.
- Level 0 gives constant low; level 2^SAMPLE_W-1 gives high for 2^SAMPLE_W-1 of every 2^SAMPLE_W cycles.
REQ-026 enable low SHALL:
- clear the tick counter;
- suppress s_rd_en;
- set levels to midscale within one cycle.
underrun_count SHALL be held, not cleared.
REQ-027 A read already issued when enable falls (FETCH) SHALL have its data discarded; no further read SHALL be issued.
REQ-028 s_rd_en SHALL never be asserted while s_empty is high, nor in two consecutive cycles.

Reset
REQ-029 While reset is low at a rising clk edge, the following SHALL hold:
- state IDLE;
- tick counter, pwm_cnt, s_rd_en, sample_tick, pwm_out and underrun_count all 0;
- levels at midscale;
- busy 0.
REQ-030 Reset asserted mid-FETCH SHALL discard the pending data.

Structure
REQ-031 Package audio_pkg SHALL hold the FSM state enum, the DIV_MIN=4 constant and a midscale function of SAMPLE_W.
REQ-032 Sub-module pwm_channel (compare register plus comparator, one instance per channel via generate) SHALL take the shared pwm_cnt as an input.

Verification
REQ-033 SAMPLE_W=8, CHANNELS=2, rate_div=100, FIFO preloaded with {0x40,0xC0} then empty:
- s_rd_en pulses once at the first tick;
- levels are 0xC0/0x40 two cycles later;
- the next tick increments underrun_count to 1 and levels return to 0x80.
REQ-034 Level 0x40, volume=0: pwm_out[0] high 64 of every 256 cycles. Level 0xFF: high 255 of 256. Level 0x00: never high.
REQ-035 Sample 0x00 with volume=1 gives level 0x40. Sample 0xFF with volume=7 gives level 0x80.
REQ-036 rate_div=2: ticks every 4 cycles. rate_div changed from 1000 to 10 at count 500: tick next cycle, then every 10 cycles.
REQ-037 enable dropped during FETCH: no further s_rd_en, levels 0x80, busy 0 next cycle. underrun_count unchanged.
REQ-038 reset low for 1 cycle mid-playback with underrun_count=5: all outputs at reset values, underrun_count 0. Empty FIFO for 70000 ticks: saturates at 0xFFFF.

Source files
------------

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared FSM type and constants for the audio stream player
package audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FETCH = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    localparam int DIV_MIN = 4;

    function automatic int midscale(input int sample_w);
        return 1 << (sample_w - 1);
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - per-channel compare register and PWM comparator
module pwm_channel import audio_pkg::*; #(
    parameter int SAMPLE_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mute,
    input  logic [SAMPLE_W-1:0] level,
    input  logic [SAMPLE_W-1:0] pwm_cnt,
    output logic                pwm_out
);

    localparam logic [SAMPLE_W-1:0] MID = SAMPLE_W'(midscale(SAMPLE_W));

    logic [SAMPLE_W-1:0] compare;

    always_ff @(posedge clk) begin
        if (!reset) begin
            compare <= MID;
            pwm_out <= 1'b0;
        end else begin
            compare <= mute ? MID : level;
            pwm_out <= (pwm_cnt < compare);
        end
    end

endmodule

// File: rtl/audio_stream_player.sv
// rtl/audio_stream_player.sv - FIFO-fed multichannel PWM audio player with sample-rate divider
module audio_stream_player import audio_pkg::*; #(
    parameter int SAMPLE_W = 8,
    parameter int CHANNELS = 2,
    parameter int DIV_W    = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [DIV_W-1:0]             rate_div,
    input  logic [2:0]                   volume,
    input  logic                         mute,
    input  logic [CHANNELS*SAMPLE_W-1:0] s_data,
    input  logic                         s_empty,
    output logic                         s_rd_en,
    output logic [CHANNELS-1:0]          pwm_out,
    output logic                         sample_tick,
    output logic [15:0]                  underrun_count,
    output logic                         busy
);

    localparam logic [SAMPLE_W-1:0] MID       = SAMPLE_W'(midscale(SAMPLE_W));
    localparam logic [DIV_W-1:0]    DIV_FLOOR = DIV_W'(DIV_MIN);

    state_t              state;
    logic [DIV_W-1:0]    tick_cnt;
    logic [DIV_W-1:0]    eff_div;
    logic [SAMPLE_W-1:0] pwm_cnt;
    logic [SAMPLE_W-1:0] level [CHANNELS];
    logic [SAMPLE_W-1:0] atten [CHANNELS];
    logic [15:0]         underrun_q;
    logic [15:0]         underrun_next;
    logic                underrun_hit;

    assign eff_div = (rate_div < DIV_FLOOR) ? DIV_FLOOR : rate_div;
    // >= rather than == so a shrinking rate_div ticks and wraps immediately
    assign sample_tick = enable && (tick_cnt >= eff_div - DIV_W'(1));

    assign s_rd_en       = (state == ST_WAIT) && sample_tick && !s_empty;
    assign underrun_hit  = (state == ST_WAIT) && sample_tick && s_empty;
    assign underrun_next = (underrun_hit && underrun_q != 16'hFFFF) ? underrun_q + 16'd1 : underrun_q;

    assign busy           = (state != ST_IDLE);
    assign underrun_count = underrun_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        // two guard bits so the clamp can see both underflow and overflow
        logic signed [SAMPLE_W+1:0] diff;
        logic signed [SAMPLE_W+1:0] scaled;
        logic signed [SAMPLE_W+1:0] sum;

        assign diff     = $signed({2'b00, s_data[c*SAMPLE_W +: SAMPLE_W]}) - $signed({2'b00, MID});
        assign scaled   = diff >>> volume;
        assign sum      = scaled + $signed({2'b00, MID});
        assign atten[c] = sum[SAMPLE_W+1] ? '0 : (sum[SAMPLE_W] ? '1 : sum[SAMPLE_W-1:0]);

        pwm_channel #(.SAMPLE_W(SAMPLE_W)) u_pwm (
            .clk     (clk),
            .reset   (reset),
            .mute    (mute),
            .level   (level[c]),
            .pwm_cnt (pwm_cnt),
            .pwm_out (pwm_out[c])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            tick_cnt   <= '0;
            pwm_cnt    <= '0;
            underrun_q <= '0;
            for (int c = 0; c < CHANNELS; c++) level[c] <= MID;
        end else begin
            pwm_cnt    <= pwm_cnt + SAMPLE_W'(1);
            underrun_q <= underrun_next;
            if (!enable) begin
                state    <= ST_IDLE;
                tick_cnt <= '0;
                for (int c = 0; c < CHANNELS; c++) level[c] <= MID;
            end else begin
                tick_cnt <= sample_tick ? '0 : tick_cnt + DIV_W'(1);
                case (state)
                    ST_IDLE: state <= ST_WAIT;
                    ST_WAIT: begin
                        if (s_rd_en) begin
                            state <= ST_FETCH;
                        end else if (underrun_hit) begin
                            for (int c = 0; c < CHANNELS; c++) level[c] <= MID;
                        end
                    end
                    // read data is valid during FETCH; levels load on the way into LATCH
                    ST_FETCH: begin
                        state <= ST_LATCH;
                        for (int c = 0; c < CHANNELS; c++) level[c] <= atten[c];
                    end
                    ST_LATCH: state <= ST_WAIT;
                    default:  state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_audio_stream_player.sv
// tb/tb_audio_stream_player.sv - randomized self-checking bench with a behavioural player model
module tb_audio_stream_player;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] rate_div = 32'd100;
    logic [2:0]  volume = 3'd0;
    logic        mute = 1'b0;
    logic [15:0] s_data = 16'h0000;
    logic        s_empty = 1'b1;
    logic        s_rd_en;
    logic [1:0]  pwm_out;
    logic        sample_tick;
    logic [15:0] underrun_count;
    logic        busy;

    audio_stream_player #(.SAMPLE_W(8), .CHANNELS(2), .DIV_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .rate_div       (rate_div),
        .volume         (volume),
        .mute           (mute),
        .s_data         (s_data),
        .s_empty        (s_empty),
        .s_rd_en        (s_rd_en),
        .pwm_out        (pwm_out),
        .sample_tick    (sample_tick),
        .underrun_count (underrun_count),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] fifo_q [$];
    logic [15:0] pend_word = 16'h0000;
    int  m_cnt = 0;
    bit  m_busy = 0;
    int  m_fetch = 0;
    int  m_under = 0;
    int  exp_lvl [2] = '{128, 128};
    bit  m_rst_prev = 1;
    bit  rd_prev = 0;
    int  mode = 0;
    int  ticks_seen = 0;
    int  reads_seen = 0;
    int  hi0 = 0;
    int  hi1 = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_level(input int sample, input int vol);
        int d;
        int q;
        int r;
        d = sample - 128;
        if (d >= 0) q = d / (1 << vol);
        else        q = -(((-d) + (1 << vol) - 1) / (1 << vol));
        r = 128 + q;
        if (r < 0)   r = 0;
        if (r > 255) r = 255;
        return r;
    endfunction

    task automatic run(input int ncycles, input int push_pct);
        for (int k = 0; k < ncycles; k++) begin
            int eff;
            bit tk;
            bit act;
            bit rd;
            @(negedge clk);
            eff = (rate_div < 4) ? 4 : int'(rate_div);
            tk  = enable && (m_cnt >= eff - 1);
            act = tk && m_busy && (m_fetch == 0);
            rd  = act && (fifo_q.size() != 0);
            check("sample_tick", sample_tick, tk);
            check("s_rd_en", s_rd_en, rd);
            check("busy", busy, m_busy);
            check("underrun_count", underrun_count, m_under);
            check("level0", dut.level[0], exp_lvl[0]);
            check("level1", dut.level[1], exp_lvl[1]);
            check("rd_protocol", s_rd_en && (s_empty || rd_prev), 0);
            if (m_rst_prev) check("pwm_out_reset", pwm_out, 0);
            rd_prev = s_rd_en;
            ticks_seen += int'(sample_tick);
            reads_seen += int'(s_rd_en);
            hi0 += int'(pwm_out[0]);
            hi1 += int'(pwm_out[1]);

            m_rst_prev = !reset;
            if (!reset) begin
                m_cnt = 0; m_busy = 0; m_fetch = 0; m_under = 0;
                exp_lvl = '{128, 128};
            end else if (!enable) begin
                m_cnt = 0; m_busy = 0; m_fetch = 0;
                exp_lvl = '{128, 128};
            end else begin
                m_cnt  = tk ? 0 : m_cnt + 1;
                m_busy = 1;
                if (m_fetch == 2) begin
                    exp_lvl[0] = ref_level(int'(pend_word[7:0]), int'(volume));
                    exp_lvl[1] = ref_level(int'(pend_word[15:8]), int'(volume));
                end
                if (m_fetch > 0) m_fetch--;
                if (rd) begin
                    m_fetch = 2;
                end else if (act) begin
                    exp_lvl = '{128, 128};
                    if (m_under < 65535) m_under++;
                end
            end

            @(posedge clk);
            #1;
            if (rd) begin
                pend_word = fifo_q.pop_front();
                s_data    = pend_word;
            end
            if (mode == 1 && rd) begin
                enable = 1'b0;
                mode   = 0;
            end
            if (mode == 4) begin
                reset = 1'b1;
                mode  = 0;
            end
            if (mode == 2 && rd) begin
                reset = 1'b0;
                mode  = 4;
            end
            if (mode == 3 && m_cnt == 500) begin
                rate_div = 32'd10;
                mode     = 0;
            end
            if (int'($urandom_range(99)) < push_pct) fifo_q.push_back(16'($urandom));
            s_empty = (fifo_q.size() == 0);
        end
    endtask

    task automatic load(input logic [15:0] word);
        fifo_q.push_back(word);
        s_empty = 1'b0;
    endtask

    task automatic flush();
        fifo_q.delete();
        s_empty = 1'b1;
    endtask

    initial begin
        int reads0;

        @(posedge clk);
        #1;
        run(3, 0);
        reset = 1'b1;
        run(5, 0);

        // preloaded pair, first tick reads, second tick underruns
        load(16'h40C0);
        rate_div = 32'd100;
        enable = 1'b1;
        reads_seen = 0;
        run(250, 0);
        check("first_read_count", reads_seen, 1);
        check("first_underrun", underrun_count, 1);
        enable = 1'b0;
        run(3, 0);
        check("underrun_held", underrun_count, 1);

        rate_div = 32'd2;
        enable = 1'b1;
        ticks_seen = 0;
        run(41, 0);
        check("rate2_ticks", ticks_seen, 10);
        enable = 1'b0;
        run(2, 0);

        rate_div = 32'd1000;
        enable = 1'b1;
        mode = 3;
        ticks_seen = 0;
        run(530, 0);
        check("rate_drop_ticks", ticks_seen, 3);
        enable = 1'b0;
        run(2, 0);

        volume = 3'd1;
        rate_div = 32'd8;
        load(16'hFF00);
        enable = 1'b1;
        run(12, 0);
        check("vol1_zero", dut.level[0], 8'h40);
        enable = 1'b0;
        run(2, 0);
        volume = 3'd7;
        load(16'h00FF);
        enable = 1'b1;
        run(12, 0);
        check("vol7_full", dut.level[0], 8'h80);
        check("vol7_zero", dut.level[1], 8'h7F);
        enable = 1'b0;
        run(2, 0);

        for (int r = 0; r < 6; r++) begin
            rate_div = 32'($urandom_range(0, 12));
            volume = 3'($urandom_range(0, 7));
            enable = 1'b1;
            run(300, 30);
            enable = 1'b0;
            run(3, 20);
        end
        flush();

        load(16'h1234);
        load(16'h5678);
        rate_div = 32'd6;
        mode = 1;
        reads0 = reads_seen;
        enable = 1'b1;
        run(40, 0);
        check("drop_reads", reads_seen - reads0, 1);
        check("drop_busy", busy, 0);
        flush();

        reset = 1'b0;
        run(1, 0);
        reset = 1'b1;
        rate_div = 32'd4;
        enable = 1'b1;
        run(20, 0);
        check("under_before_reset", underrun_count, 5);
        load(16'hA55A);
        mode = 2;
        run(20, 0);
        flush();
        enable = 1'b0;
        run(2, 0);

        force dut.underrun_q = 16'hFFFB;
        @(posedge clk);
        #1;
        release dut.underrun_q;
        m_under = 65531;
        enable = 1'b1;
        run(40, 0);
        check("under_saturated", underrun_count, 16'hFFFF);
        enable = 1'b0;
        run(2, 0);

        volume = 3'd0;
        mute = 1'b0;
        load(16'h0040);
        load(16'hFFFF);
        load(16'h00FF);
        rate_div = 32'd600;
        enable = 1'b1;
        run(610, 0);
        hi0 = 0; hi1 = 0;
        run(256, 0);
        check("duty_40", hi0, 64);
        check("duty_00", hi1, 0);
        run(344, 0);
        hi0 = 0; hi1 = 0;
        run(256, 0);
        check("duty_ff_ch0", hi0, 255);
        check("duty_ff_ch1", hi1, 255);
        run(344, 0);
        mute = 1'b1;
        run(2, 0);
        hi0 = 0; hi1 = 0;
        run(256, 0);
        check("mute_ch0", hi0, 128);
        check("mute_ch1", hi1, 128);
        mute = 1'b0;
        enable = 1'b0;
        run(3, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
